thermo_maj_ctrl: RTL

Sequencing controller for the thermo_maj datapath (four 15-bit thermometer codes -> 4-bit binary of the second-largest value). It accepts thermometer samples one at a time over a valid/ready stream, assembles groups of four, and evaluates each group through one thermo_maj instance. It returns a registered result with an output valid/ready handshake, flags illegal thermometer codes, and counts completed groups. It sits between a serial sample source and downstream consumers of the second-largest value.

---
 rtl/thermo_pkg.sv | 20 ++
 rtl/thermo_maj.sv | 30 +++
 rtl/thermo_maj_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/thermo_pkg.sv
// Shared constants, FSM encoding and the thermometer-legality helper for the
// thermo_maj controller slice.
package thermo_pkg;

  localparam int WIDTH = 15;  // thermometer code width
  localparam int BIN_W = 4;   // clog2(WIDTH+1)

  typedef logic [1:0] state_t;

  localparam state_t COLLECT = 2'd0;
  localparam state_t EVAL    = 2'd1;
  localparam state_t HOLD    = 2'd2;

  // A legal code is a run of ones starting at bit 0 (all-zero and all-one
  // included): adding one then carries through the whole run, clearing it.
  function automatic logic is_thermo(input logic [WIDTH-1:0] x);
    return (x & (x + WIDTH'(1))) == '0;
  endfunction

endpackage

// File: rtl/thermo_maj.sv
// Second-largest of four thermometer codes, returned as a binary count.
// A bit is set in the second-largest code exactly when at least two of the
// four inputs have it set, so a per-bit 2-of-4 vote followed by a popcount
// yields the answer without any magnitude comparisons.
module thermo_maj
  import thermo_pkg::*;
(
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [BIN_W-1:0] out_bin
);

  logic [WIDTH-1:0] vote;

  assign vote = (in0 & in1) | (in0 & in2) | (in0 & in3)
              | (in1 & in2) | (in1 & in3) | (in2 & in3);

  // Count the voted bits to turn the thermometer code into binary.
  always_comb begin
    // NOTE: the accumulator gets a default before the loop; without it the
    // block would have to remember a prior value and a latch would be inferred.
    out_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_bin = out_bin + BIN_W'(vote[i]);
    end
  end

endmodule

// File: rtl/thermo_maj_ctrl.sv
// Sequencing controller: gathers four thermometer samples over a valid/ready
// stream, evaluates them through one thermo_maj, and presents a registered
// result (with an illegal-code flag) until the consumer takes it.
module thermo_maj_ctrl
  import thermo_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_therm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_bin,
  output logic             out_err,
  output logic [1:0]       slot,
  output logic [CNT_W-1:0] grp_cnt
);

  state_t           state;
  logic [WIDTH-1:0] samp [4];
  logic             err_acc;
  logic [BIN_W-1:0] maj_bin;

  // Samples are only taken while collecting; EVAL and HOLD back-pressure.
  assign in_ready = (state == COLLECT);

  thermo_maj u_maj (
    .in0     (samp[0]),
    .in1     (samp[1]),
    .in2     (samp[2]),
    .in3     (samp[3]),
    .out_bin (maj_bin)
  );

  // Sample storage: the slot pointed at by slot captures each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the four sample registers are reset explicitly so the evaluator
      // never sees X after reset; this storage is small enough to stay in flops.
      for (int i = 0; i < 4; i++) begin
        samp[i] <= '0;
      end
    end else if (!clear && state == COLLECT && in_valid) begin
      samp[slot] <= in_therm;
    end
  end

  // Control FSM, slot pointer, error accumulator, result and group counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // updates from pre-edge values, independent of statement order.
      state     <= COLLECT;
      slot      <= '0;
      err_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
      grp_cnt   <= '0;
    end else if (clear) begin
      // Abort wins over any handshake this cycle; out_bin and grp_cnt survive.
      state     <= COLLECT;
      slot      <= '0;
      err_acc   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            err_acc <= err_acc | ~is_thermo(in_therm);
            if (slot == 2'd3) begin
              slot  <= '0;
              state <= EVAL;
            end else begin
              slot <= slot + 2'd1;
            end
          end
        end
        EVAL: begin
          out_bin   <= maj_bin;
          out_err   <= err_acc;
          out_valid <= 1'b1;
          err_acc   <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            grp_cnt   <= grp_cnt + CNT_W'(1);
            state     <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule
